sprite_line_compositor: RTL
===========================

SPRITE_LINE_COMPOSITOR -- requirements
Module: sprite_line_compositor

Interface
REQ-001 Parameter N_SLOTS, default 11: number of sprite slots presented by the game logic.
REQ-002 Parameter MAX_PER_LINE, default 4: active-list depth per scanline.
REQ-003 Parameter SPRITE_SIZE, default 32: sprite width and height in pixels (power of two).
REQ-004 Port clk, input, 1: single clock; all state is on its rising edge.
REQ-005 Port reset_n, input, 1: asynchronous active-low reset.
REQ-006 Port vs, input, 1: VGA vertical sync, active low.
REQ-007 Port hs, input, 1: VGA horizontal sync, active low.
REQ-008 Port DrawX, input, 10: current pixel column.
REQ-009 Port DrawY, input, 10: current pixel row.
REQ-010 Port posX, input, N_SLOTS x 10: per-slot left edge.
REQ-011 Port posY, input, N_SLOTS x 10: per-slot top edge.
REQ-012 Port spriteID, input, N_SLOTS x 4: per-slot sprite ID; 0 = slot empty.
REQ-013 Port pix_valid, output, 1: a sprite covers the pixel.
REQ-014 Port pix_sprite_id, output, 4: ID of the winning sprite.
REQ-015 Port pix_row and pix_col, output, 5 each: offset inside the sprite, for the ROM address.
REQ-016 Port line_overflow, output, 1: more than MAX_PER_LINE sprites hit the current line.

Function
REQ-017 The block SHALL detect vs and hs falling edges from registered copies of each input.
REQ-018 On a vs falling edge, the block SHALL copy all slot inputs into a shadow table in one cycle; all later logic uses only the shadow table.
REQ-019 On an hs falling edge, the FSM SHALL go IDLE -> SCAN and compute target line = DrawY+1, wrapping 524 -> 0.
REQ-020 In SCAN, the FSM SHALL test one slot per cycle, index 0 to N_SLOTS-1, which is N_SLOTS cycles, then return to IDLE.
REQ-021 A slot SHALL hit when its ID is nonzero and (target - posY) mod 1024 < SPRITE_SIZE, using a 10-bit unsigned subtract.
REQ-022 Hits SHALL fill a back active list in slot order; hits beyond MAX_PER_LINE are dropped and set the back overflow bit.
REQ-023 When SCAN ends, the back list and overflow bit SHALL move to the front list and line_overflow, and the back list SHALL be cleared.
REQ-024 The pixel stage SHALL, each cycle, match DrawX against the front list: (DrawX - posX) mod 1024 < SPRITE_SIZE.
REQ-025 On a match, the lowest list index SHALL win; the outputs are registered with exactly 1-cycle latency.
REQ-026 For the winner, pix_row = (DrawY - posY)[4:0] and pix_col = (DrawX - posX)[4:0]; on no match, pix_valid=0 and the other pixel outputs are 0.
REQ-027 If vs and hs fall in the same cycle, the capture SHALL take effect first and the scan SHALL use the new table.
REQ-028 An hs falling edge during SCAN SHALL be ignored.

Reset
REQ-029 While reset_n=0, the block SHALL hold the FSM in IDLE.
REQ-030 While reset_n=0, the shadow table, both lists, the edge registers and all outputs SHALL be 0.
REQ-031 A reset in the middle of SCAN SHALL abort it, and no partial list reaches the front.

Configuration
REQ-032 With SPRITE_OVERFLOW_CNT_EN defined, the block SHALL add an output ovf_count[7:0].
REQ-033 ovf_count SHALL count the lines in the current frame with overflow, saturating at 255.
REQ-034 ovf_count SHALL clear on each vs falling edge.
REQ-035 Without SPRITE_OVERFLOW_CNT_EN, the port and the counter SHALL NOT exist.

Structure
REQ-036 Package sprite_pkg SHALL hold the constants (N_SLOTS, MAX_PER_LINE, SPRITE_SIZE, LINE_WRAP=524), the sprite_t struct {x,y,id} and the scan-state enum.
REQ-037 The SCAN FSM and back list SHALL be sub-module sprite_line_scanner; the pixel stage stays in the top module.

Verification
REQ-038 Slot0 {x=100,y=50,id=3}, vs fall, then hs fall with DrawY=49, then DrawX=100, DrawY=50 -> next cycle pix_valid=1, id=3, row=0, col=0.
REQ-039 Same sprite, DrawX=132 -> pix_valid=0; DrawX=131 -> col=31.
REQ-040 Five slots hit line 200 (slots 0-4) -> slots 0-3 listed, slot 4 dropped, line_overflow=1.
REQ-041 Slots 2 and 5 overlap at a pixel -> pix_sprite_id is that of slot 2.
REQ-042 posY=1020 with target line 4 -> hit, row=8 (wrap-around).
REQ-043 reset_n pulsed low on SCAN cycle 5 -> all outputs 0; the next line scan produces a correct list.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared constants, slot record and scan-state encoding for the sprite line compositor.
package sprite_pkg;

  localparam int unsigned N_SLOTS      = 11;
  localparam int unsigned MAX_PER_LINE = 4;
  localparam int unsigned SPRITE_SIZE  = 32;
  localparam int unsigned LINE_WRAP    = 524;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] id;
  } sprite_t;

  typedef enum logic {
    ScanIdle = 1'b0,
    ScanRun  = 1'b1
  } scan_state_e;

  // Line following y in a 525-line frame.
  function automatic logic [9:0] next_line(input logic [9:0] y);
    return (y == 10'(LINE_WRAP)) ? 10'd0 : y + 10'd1;
  endfunction

endpackage

// File: rtl/sprite_line_scanner.sv
// Per-scanline slot scan: tests one shadow slot per cycle, builds the back active list and
// hands it to the front list when the scan completes.
module sprite_line_scanner #(
  parameter int unsigned N_SLOTS      = sprite_pkg::N_SLOTS,
  parameter int unsigned MAX_PER_LINE = sprite_pkg::MAX_PER_LINE,
  parameter int unsigned SPRITE_SIZE  = sprite_pkg::SPRITE_SIZE
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_start,
  input  logic [9:0]                 i_draw_y,
  input  logic [N_SLOTS*10-1:0]      i_slot_x,
  input  logic [N_SLOTS*10-1:0]      i_slot_y,
  input  logic [N_SLOTS*4-1:0]       i_slot_id,
  output logic [MAX_PER_LINE*10-1:0] o_front_x,
  output logic [MAX_PER_LINE*10-1:0] o_front_y,
  output logic [MAX_PER_LINE*4-1:0]  o_front_id,
  output logic                       o_overflow,
  output logic                       o_done
);
  import sprite_pkg::*;

  localparam int unsigned IDX_W  = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int unsigned LIST_W = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;
  localparam int unsigned CNT_W  = $clog2(MAX_PER_LINE + 1);

  scan_state_e      r_state;
  logic [IDX_W-1:0] r_idx;
  logic [9:0]       r_target;
  sprite_t          r_back [MAX_PER_LINE];
  sprite_t          r_front[MAX_PER_LINE];
  logic [CNT_W-1:0] r_back_cnt;
  logic             r_back_ovf;
  logic             r_front_ovf;
  logic             r_done;

  sprite_t          w_slots [N_SLOTS];
  sprite_t          w_slot;
  logic [9:0]       w_dy;
  logic             w_hit;
  logic             w_last;
  sprite_t          w_back_d[MAX_PER_LINE];
  logic [CNT_W-1:0] w_cnt_d;
  logic             w_ovf_d;

  always_comb begin
    for (int i = 0; i < int'(N_SLOTS); i++) begin
      w_slots[i].x  = i_slot_x[10*i +: 10];
      w_slots[i].y  = i_slot_y[10*i +: 10];
      w_slots[i].id = i_slot_id[4*i +: 4];
    end
  end

  // Empty list entries carry id 0, so no separate valid bits are kept.
  always_comb begin
    w_slot   = w_slots[r_idx];
    w_dy     = r_target - w_slot.y;
    w_hit    = (r_state == ScanRun) && (w_slot.id != 4'd0) && (w_dy < 10'(SPRITE_SIZE));
    w_last   = (r_idx == IDX_W'(N_SLOTS - 1));
    w_back_d = r_back;
    w_cnt_d  = r_back_cnt;
    w_ovf_d  = r_back_ovf;
    if (w_hit) begin
      if (r_back_cnt < CNT_W'(MAX_PER_LINE)) begin
        w_back_d[r_back_cnt[LIST_W-1:0]] = w_slot;
        w_cnt_d = r_back_cnt + CNT_W'(1);
      end else begin
        w_ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ScanIdle;
      r_idx       <= '0;
      r_target    <= '0;
      r_back_cnt  <= '0;
      r_back_ovf  <= 1'b0;
      r_front_ovf <= 1'b0;
      r_done      <= 1'b0;
      for (int i = 0; i < int'(MAX_PER_LINE); i++) begin
        r_back[i]  <= '0;
        r_front[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ScanIdle: begin
          if (i_start) begin
            r_state  <= ScanRun;
            r_idx    <= '0;
            r_target <= next_line(i_draw_y);
          end
        end
        ScanRun: begin
          r_idx <= r_idx + IDX_W'(1);
          if (w_last) begin
            r_state     <= ScanIdle;
            r_front     <= w_back_d;
            r_front_ovf <= w_ovf_d;
            r_back_cnt  <= '0;
            r_back_ovf  <= 1'b0;
            r_done      <= 1'b1;
            for (int i = 0; i < int'(MAX_PER_LINE); i++) r_back[i] <= '0;
          end else begin
            r_back     <= w_back_d;
            r_back_cnt <= w_cnt_d;
            r_back_ovf <= w_ovf_d;
          end
        end
        default: r_state <= ScanIdle;
      endcase
    end
  end

  for (genvar g = 0; g < int'(MAX_PER_LINE); g++) begin : g_front
    assign o_front_x[10*g +: 10] = r_front[g].x;
    assign o_front_y[10*g +: 10] = r_front[g].y;
    assign o_front_id[4*g +: 4]  = r_front[g].id;
  end

  assign o_overflow = r_front_ovf;
  assign o_done     = r_done;

endmodule

// File: rtl/sprite_line_compositor.sv
// Sprite line compositor: frame-synchronous slot capture, per-line scan and pixel match.
// Optional build macro SPRITE_OVERFLOW_CNT_EN adds the per-frame overflow line counter ovf_count.
module sprite_line_compositor #(
  parameter int unsigned N_SLOTS      = sprite_pkg::N_SLOTS,
  parameter int unsigned MAX_PER_LINE = sprite_pkg::MAX_PER_LINE,
  parameter int unsigned SPRITE_SIZE  = sprite_pkg::SPRITE_SIZE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  vs,
  input  logic                  hs,
  input  logic [9:0]            DrawX,
  input  logic [9:0]            DrawY,
  input  logic [N_SLOTS*10-1:0] posX,
  input  logic [N_SLOTS*10-1:0] posY,
  input  logic [N_SLOTS*4-1:0]  spriteID,
  output logic                  pix_valid,
  output logic [3:0]            pix_sprite_id,
  output logic [4:0]            pix_row,
  output logic [4:0]            pix_col,
  output logic                  line_overflow
`ifdef SPRITE_OVERFLOW_CNT_EN
  ,
  output logic [7:0]            ovf_count
`endif
);
  import sprite_pkg::*;

  logic                      r_vs;
  logic                      r_hs;
  logic [N_SLOTS*10-1:0]     r_shadow_x;
  logic [N_SLOTS*10-1:0]     r_shadow_y;
  logic [N_SLOTS*4-1:0]      r_shadow_id;
  logic                      r_pix_valid;
  logic [3:0]                r_pix_id;
  logic [4:0]                r_pix_row;
  logic [4:0]                r_pix_col;

  logic                      w_vs_fall;
  logic                      w_hs_fall;
  logic [MAX_PER_LINE*10-1:0] w_front_x;
  logic [MAX_PER_LINE*10-1:0] w_front_y;
  logic [MAX_PER_LINE*4-1:0] w_front_id;
  logic                      w_overflow;
  logic                      w_done;
  sprite_t                   w_front[MAX_PER_LINE];
  logic [9:0]                w_dx   [MAX_PER_LINE];
  logic [4:0]                w_dy   [MAX_PER_LINE];
  logic                      w_match[MAX_PER_LINE];
  logic                      w_win_valid;
  logic [3:0]                w_win_id;
  logic [4:0]                w_win_row;
  logic [4:0]                w_win_col;

  assign w_vs_fall = r_vs & ~vs;
  assign w_hs_fall = r_hs & ~hs;

  // Capture and scan start share an edge; the scanner reads the shadow a cycle later,
  // so a coincident vs/hs fall scans the freshly captured table.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vs        <= 1'b0;
      r_hs        <= 1'b0;
      r_shadow_x  <= '0;
      r_shadow_y  <= '0;
      r_shadow_id <= '0;
    end else begin
      r_vs <= vs;
      r_hs <= hs;
      if (w_vs_fall) begin
        r_shadow_x  <= posX;
        r_shadow_y  <= posY;
        r_shadow_id <= spriteID;
      end
    end
  end

  sprite_line_scanner #(
    .N_SLOTS      (N_SLOTS),
    .MAX_PER_LINE (MAX_PER_LINE),
    .SPRITE_SIZE  (SPRITE_SIZE)
  ) u_scanner (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_start    (w_hs_fall),
    .i_draw_y   (DrawY),
    .i_slot_x   (r_shadow_x),
    .i_slot_y   (r_shadow_y),
    .i_slot_id  (r_shadow_id),
    .o_front_x  (w_front_x),
    .o_front_y  (w_front_y),
    .o_front_id (w_front_id),
    .o_overflow (w_overflow),
    .o_done     (w_done)
  );

  always_comb begin
    for (int i = 0; i < int'(MAX_PER_LINE); i++) begin
      w_front[i].x  = w_front_x[10*i +: 10];
      w_front[i].y  = w_front_y[10*i +: 10];
      w_front[i].id = w_front_id[4*i +: 4];
      w_dx[i]       = DrawX - w_front[i].x;
      w_dy[i]       = 5'(DrawY - w_front[i].y);
      w_match[i]    = (w_front[i].id != 4'd0) && (w_dx[i] < 10'(SPRITE_SIZE));
    end
  end

  // Walk from the top so the lowest list index is the last writer.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_id    = '0;
    w_win_row   = '0;
    w_win_col   = '0;
    for (int i = int'(MAX_PER_LINE) - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_win_valid = 1'b1;
        w_win_id    = w_front[i].id;
        w_win_row   = w_dy[i];
        w_win_col   = w_dx[i][4:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pix_valid <= 1'b0;
      r_pix_id    <= '0;
      r_pix_row   <= '0;
      r_pix_col   <= '0;
    end else begin
      r_pix_valid <= w_win_valid;
      r_pix_id    <= w_win_id;
      r_pix_row   <= w_win_row;
      r_pix_col   <= w_win_col;
    end
  end

  assign pix_valid     = r_pix_valid;
  assign pix_sprite_id = r_pix_id;
  assign pix_row       = r_pix_row;
  assign pix_col       = r_pix_col;
  assign line_overflow = w_overflow;

`ifdef SPRITE_OVERFLOW_CNT_EN
  logic [7:0] r_ovf_count;

  // w_done follows the front-list update, so w_overflow already reflects the finished line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf_count <= '0;
    end else if (w_vs_fall) begin
      r_ovf_count <= '0;
    end else if (w_done && w_overflow && (r_ovf_count != 8'hff)) begin
      r_ovf_count <= r_ovf_count + 8'd1;
    end
  end

  assign ovf_count = r_ovf_count;
`else
  logic w_unused_done;
  assign w_unused_done = w_done;
`endif

endmodule
